// File: rtl/nw_pkg.sv
// Shared FSM state type and matrix addressing helper for the score RAM writer.
package nw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_ROW,
    ST_INIT_COL,
    ST_FILL,
    ST_DONE
  } nw_state_t;

  // Row-major address of (row, col) in an (n+1)-wide matrix; 32-bit products never truncate valid addresses.
  function automatic logic [31:0] nw_cell_addr(input logic [31:0] row,
                                               input logic [31:0] col,
                                               input logic [31:0] n);
    return row * (n + 32'd1) + col;
  endfunction

endpackage

// File: rtl/score_addr_gen.sv
// Address/data sequencing for the boundary init writes (row 0, column 0) and interior cell writes.
module score_addr_gen
  import nw_pkg::*;
#(
  parameter int N       = 128,
  parameter int SCORE_W = 9,
  parameter int GAP     = -1,
  parameter int IDX_W   = $clog2(N) + 1,
  parameter int ADDR_W  = $clog2((N + 1) * (N + 1))
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  nw_state_t          i_state,
  input  logic               i_wr_done,
  input  logic [IDX_W-1:0]   i_cell_i,
  input  logic [IDX_W-1:0]   i_cell_j,
  input  logic [SCORE_W-1:0] i_cell_score,
  output logic               o_init_more,
  output logic               o_init_last,
  output logic [ADDR_W-1:0]  o_init_addr,
  output logic [SCORE_W-1:0] o_init_data,
  output logic [ADDR_W-1:0]  o_cell_addr,
  output logic [SCORE_W-1:0] o_cell_data
);

  localparam logic [IDX_W:0] LAST_K = (IDX_W + 1)'(N);

  logic [IDX_W-1:0] r_k;
  logic [IDX_W:0]   w_k_ext;
  logic [IDX_W:0]   w_issue_k;
  logic             w_init_phase;

  assign w_init_phase = (i_state == ST_INIT_ROW) || (i_state == ST_INIT_COL);
  assign w_k_ext      = {1'b0, r_k};
  // r_k names the write currently held (or about to be issued); the next one is issued as it completes.
  assign w_issue_k    = i_wr_done ? (w_k_ext + (IDX_W + 1)'(1)) : w_k_ext;
  assign o_init_more  = (w_issue_k <= LAST_K);
  assign o_init_last  = (w_k_ext == LAST_K);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_k <= '0;
    end else if (i_state == ST_IDLE) begin
      r_k <= '0;
    end else if (w_init_phase && i_wr_done) begin
      if ((i_state == ST_INIT_ROW) && o_init_last) begin
        r_k <= IDX_W'(1);
      end else begin
        r_k <= w_issue_k[IDX_W-1:0];
      end
    end
  end

  assign o_init_addr = (i_state == ST_INIT_COL)
                     ? ADDR_W'(nw_cell_addr(32'(w_issue_k), 32'd0, 32'(N)))
                     : ADDR_W'(nw_cell_addr(32'd0, 32'(w_issue_k), 32'(N)));
  assign o_init_data = SCORE_W'(int'(w_issue_k) * GAP);

  assign o_cell_addr = ADDR_W'(nw_cell_addr(32'(i_cell_i) + 32'd1, 32'(i_cell_j) + 32'd1, 32'(N)));
  assign o_cell_data = i_cell_score;

endmodule

// File: rtl/score_ram_writer.sv
// Fills an (N+1)x(N+1) score matrix RAM: gap-penalty borders, then streamed interior cells.
// Optional bounds checking of incoming cell indices: define SCORE_RAM_WRITER_BOUNDS_CHECK_EN.
module score_ram_writer
  import nw_pkg::*;
#(
  parameter int N       = 128,
  parameter int SCORE_W = 9,
  parameter int GAP     = -1,
  parameter int IDX_W   = $clog2(N) + 1,
  parameter int ADDR_W  = $clog2((N + 1) * (N + 1))
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cell_valid,
  output logic               cell_ready,
  input  logic [IDX_W-1:0]   cell_i,
  input  logic [IDX_W-1:0]   cell_j,
  input  logic [SCORE_W-1:0] cell_score,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [SCORE_W-1:0] wr_data,
  input  logic               wr_ready,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(N * N - 1);

  nw_state_t          r_state;
  nw_state_t          w_state_next;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [SCORE_W-1:0] r_wr_data;
  logic [ADDR_W-1:0]  r_fill;

  logic               w_complete;
  logic               w_can_load;
  logic               w_init_phase;
  logic               w_load_init;
  logic               w_accept;
  logic               w_load_cell;
  logic               w_fill_last;
  logic               w_bad;
  logic               w_init_more;
  logic               w_init_last;
  logic [ADDR_W-1:0]  w_init_addr;
  logic [SCORE_W-1:0] w_init_data;
  logic [ADDR_W-1:0]  w_cell_addr;
  logic [SCORE_W-1:0] w_cell_data;

  score_addr_gen #(
    .N(N), .SCORE_W(SCORE_W), .GAP(GAP), .IDX_W(IDX_W), .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_state      (r_state),
    .i_wr_done    (w_complete),
    .i_cell_i     (cell_i),
    .i_cell_j     (cell_j),
    .i_cell_score (cell_score),
    .o_init_more  (w_init_more),
    .o_init_last  (w_init_last),
    .o_init_addr  (w_init_addr),
    .o_init_data  (w_init_data),
    .o_cell_addr  (w_cell_addr),
    .o_cell_data  (w_cell_data)
  );

  assign w_complete  = r_wr_en && wr_ready;
  assign w_can_load  = !r_wr_en || wr_ready;
  // Register holds the final cell write: stop accepting so nothing is left pending at DONE.
  assign w_fill_last = r_wr_en && (r_fill == FILL_LAST);
  assign w_accept    = cell_valid && cell_ready;
  assign w_load_init = w_init_phase && w_can_load && w_init_more;
  assign w_load_cell = w_accept && !w_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (start) w_state_next = ST_INIT_ROW;
      ST_INIT_ROW: if (w_complete && w_init_last) w_state_next = ST_INIT_COL;
      ST_INIT_COL: if (w_complete && w_init_last) w_state_next = ST_FILL;
      ST_FILL:     if (w_complete && (r_fill == FILL_LAST)) w_state_next = ST_DONE;
      ST_DONE:     w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (r_state != ST_IDLE);
    done         = (r_state == ST_DONE);
    w_init_phase = (r_state == ST_INIT_ROW) || (r_state == ST_INIT_COL);
    cell_ready   = (r_state == ST_FILL) && w_can_load && !w_fill_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_load_init) begin
      r_wr_en   <= 1'b1;
      r_wr_addr <= w_init_addr;
      r_wr_data <= w_init_data;
    end else if (w_load_cell) begin
      r_wr_en   <= 1'b1;
      r_wr_addr <= w_cell_addr;
      r_wr_data <= w_cell_data;
    end else if (w_complete) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= '0;
    end else if (r_state == ST_IDLE) begin
      r_fill <= '0;
    end else if ((r_state == ST_FILL) && w_complete) begin
      r_fill <= r_fill + ADDR_W'(1);
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

`ifdef SCORE_RAM_WRITER_BOUNDS_CHECK_EN
  logic r_err;

  assign w_bad = (cell_i >= IDX_W'(N)) || (cell_j >= IDX_W'(N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept && w_bad) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_bad = 1'b0;
  assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_score_ram_writer.sv
// Self-checking bench for score_ram_writer (N=4): border init, randomized cell fill, backpressure, reset.
module tb_score_ram_writer;

  localparam int N       = 4;
  localparam int SCORE_W = 9;
  localparam int GAP     = -1;
  localparam int IDX_W   = $clog2(N) + 1;
  localparam int ADDR_W  = $clog2((N + 1) * (N + 1));
`ifdef SCORE_RAM_WRITER_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               cell_valid = 1'b0;
  logic               cell_ready;
  logic [IDX_W-1:0]   cell_i = '0;
  logic [IDX_W-1:0]   cell_j = '0;
  logic [SCORE_W-1:0] cell_score = '0;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [SCORE_W-1:0] wr_data;
  logic               wr_ready = 1'b1;
  logic               busy;
  logic               done;
  logic               err;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          rdy_mode = 1'b0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [31:0] got_a[$];
  logic [31:0] got_d[$];

  always #5 clk = ~clk;

  score_ram_writer #(
    .N(N), .SCORE_W(SCORE_W), .GAP(GAP), .IDX_W(IDX_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cell_valid (cell_valid),
    .cell_ready (cell_ready),
    .cell_i     (cell_i),
    .cell_j     (cell_j),
    .cell_score (cell_score),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: score truncated to SCORE_W bits, row-major address of interior cell.
  function automatic logic [31:0] sc(input int v);
    logic [31:0] t;
    t = v;
    return t & ((32'd1 << SCORE_W) - 32'd1);
  endfunction

  function automatic logic [31:0] cell_addr_m(input int i, input int j);
    return (i + 1) * (N + 1) + (j + 1);
  endfunction

  // Random write backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) wr_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Write monitor: logs completed writes, checks hold-under-stall and zeroed idle outputs.
  initial begin
    bit          prev_pend;
    logic [31:0] prev_a;
    logic [31:0] prev_d;
    prev_pend = 1'b0;
    prev_a    = '0;
    prev_d    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_pend = 1'b0;
      end else begin
        if (prev_pend) begin
          chk("hold_en", 32'(wr_en), 32'd1);
          chk("hold_addr", 32'(wr_addr), prev_a);
          chk("hold_data", 32'(wr_data), prev_d);
        end
        if (!wr_en) begin
          chk("idle_addr", 32'(wr_addr), 32'd0);
          chk("idle_data", 32'(wr_data), 32'd0);
        end else if (wr_ready) begin
          got_a.push_back(32'(wr_addr));
          got_d.push_back(32'(wr_data));
        end
        prev_pend = wr_en && !wr_ready;
        prev_a    = 32'(wr_addr);
        prev_d    = 32'(wr_data);
      end
    end
  end

  task automatic send_cell(input int i, input int j, input int s, input bit expect_w);
    bit acc;
    acc = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk);
    #1;
    cell_i     = IDX_W'(i);
    cell_j     = IDX_W'(j);
    cell_score = SCORE_W'(s);
    cell_valid = 1'b1;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk);
      acc = cell_ready;
    end
    chk("cell_accept", 32'(acc), 32'd1);
    @(posedge clk);
    #1;
    cell_valid = 1'b0;
    if (expect_w) begin
      exp_a.push_back(cell_addr_m(i, j));
      exp_d.push_back(sc(s));
    end
    $display("cell i=%0d j=%0d score=%0d accepted=%0d", i, j, s, acc);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({pfx, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({pfx, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_done"}, 32'(done), 32'd0);
    chk({pfx, "_err"}, 32'(err), 32'd0);
    chk({pfx, "_cell_ready"}, 32'(cell_ready), 32'd0);
  endtask

  initial begin
    int ci[16];
    int cj[16];
    int idx;
    int nsend;
    int tmp;
    int b;
    bit ok;

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k <= N; k++) begin
      exp_a.push_back(k);
      exp_d.push_back(sc(k * GAP));
    end
    for (int k = 1; k <= N; k++) begin
      exp_a.push_back(k * (N + 1));
      exp_d.push_back(sc(k * GAP));
    end

    // Border init with a 3-cycle stall on row write k=2
    pulse_start();
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = wr_en && (wr_addr == ADDR_W'(1));
    end
    chk("row_k1_seen", 32'(ok), 32'd1);
    @(posedge clk);
    #1 wr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_en", 32'(wr_en), 32'd1);
      chk("stall_addr", 32'(wr_addr), 32'd2);
      chk("stall_data", 32'(wr_data), sc(2 * GAP));
      chk("stall_busy", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1 wr_ready = 1'b1;
    @(negedge clk);
    chk("resume_addr2", 32'(wr_addr), 32'd2);
    @(negedge clk);
    chk("next_k3_en", 32'(wr_en), 32'd1);
    chk("next_k3_addr", 32'(wr_addr), 32'd3);
    $display("init row stall step done");

    // First cell, then a stall with the register full
    send_cell(0, 0, 7, 1'b1);
    wr_ready = 1'b0;
    @(negedge clk);
    chk("cell00_addr", 32'(wr_addr), 32'd6);
    chk("cell00_data", 32'(wr_data), 32'd7);
    chk("fill_stall_ready0", 32'(cell_ready), 32'd0);
    @(negedge clk);
    chk("fill_stall_ready1", 32'(cell_ready), 32'd0);
    @(posedge clk);
    #1 rdy_mode = 1'b1;

    idx = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!(i == 0 && j == 0)) begin
          ci[idx] = i;
          cj[idx] = j;
          idx++;
        end
      end
    end
    for (int a = idx - 1; a > 0; a--) begin
      b      = $urandom_range(0, a);
      tmp    = ci[a]; ci[a] = ci[b]; ci[b] = tmp;
      tmp    = cj[a]; cj[a] = cj[b]; cj[b] = tmp;
    end
    nsend = BOUNDS ? idx : idx - 1;

    for (int q = 0; q < nsend; q++) begin
      if (q == 5) begin
        send_cell(N, 0, $urandom_range(0, 511), !BOUNDS);
        @(negedge clk);
        chk("oob_err", 32'(err), 32'(BOUNDS));
      end
      if (q == 8) begin
        pulse_start();
        @(negedge clk);
        chk("mid_start_busy", 32'(busy), 32'd1);
      end
      send_cell(ci[q], cj[q], $urandom_range(0, 511), 1'b1);
    end

    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = done;
    end
    chk("done_seen", 32'(ok), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_cell_ready", 32'(cell_ready), 32'd0);
    chk("err_sticky", 32'(err), 32'(BOUNDS));
    rdy_mode = 1'b0;
    wr_ready = 1'b1;

    chk("write_count", 32'(got_a.size()), 32'(exp_a.size()));
    for (int w = 0; w < exp_a.size() && w < got_a.size(); w++) begin
      chk($sformatf("wr%0d_addr", w), got_a[w], exp_a[w]);
      chk($sformatf("wr%0d_data", w), got_d[w], exp_d[w]);
    end
    $display("fill run: %0d writes logged, %0d expected", got_a.size(), exp_a.size());

    // Reset during INIT_COL at k=2, then restart
    pulse_start();
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      ok = wr_en && (wr_addr == ADDR_W'(2 * (N + 1)));
    end
    chk("col_k2_seen", 32'(ok), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    got_a.delete();
    got_d.delete();
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    for (int c = 0; c < 20 && got_a.size() == 0; c++) @(negedge clk);
    chk("restart_seen", 32'(got_a.size() > 0), 32'd1);
    if (got_a.size() > 0) begin
      chk("restart_addr", got_a[0], 32'd0);
      chk("restart_data", got_d[0], 32'd0);
    end
    $display("reset/restart step done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/score_ram_writer.md
SCORE_RAM_WRITER -- requirements
Module: score_ram_writer

Interface
REQ-001 SHALL have parameter N, default 128, sequence length (matrix is (N+1)x(N+1)).
REQ-002 SHALL have parameter SCORE_W, default 9, signed two's-complement score width.
REQ-003 SHALL have parameter GAP, default -1, signed linear gap penalty.
REQ-004 SHALL have derived parameters IDX_W = clog2(N)+1 and ADDR_W = clog2((N+1)*(N+1)).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse that begins a matrix fill.
REQ-008 SHALL have ports cell_valid (input, 1), cell_ready (output, 1): cell-write handshake.
REQ-009 SHALL have ports cell_i, cell_j (input, IDX_W each), 0-based cell indices.
REQ-010 SHALL have port cell_score  input  SCORE_W  cell max score.
REQ-011 SHALL have ports wr_en (output, 1), wr_addr (output, ADDR_W), wr_data (output, SCORE_W), wr_ready (input, 1): RAM write port.
REQ-012 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse), err (output, 1, sticky).

Function
REQ-013 SHALL implement FSM IDLE, INIT_ROW, INIT_COL, FILL, DONE.
REQ-014 IDLE SHALL go to INIT_ROW on start; start in any other state SHALL be ignored.
REQ-015 INIT_ROW SHALL issue N+1 writes, k=0..N: addr k, data k*GAP truncated to SCORE_W.
REQ-016 INIT_COL SHALL issue N writes, k=1..N: addr k*(N+1), data k*GAP truncated to SCORE_W.
REQ-017 FILL SHALL accept a cell when cell_valid && cell_ready and write addr (cell_i+1)*(N+1)+(cell_j+1), data cell_score.
REQ-018 Output SHALL be a one-entry register: wr_en/wr_addr/wr_data held stable until wr_ready is high.
REQ-019 A write SHALL complete on a cycle where wr_en && wr_ready.
REQ-020 cell_ready SHALL be 1 only in FILL, when the output register is empty or completing this cycle.
REQ-021 Latency from an accepted cell, or init-counter step, to wr_en SHALL be one cycle.
REQ-022 Init counters SHALL advance only on completed writes; no write is skipped or duplicated under backpressure.
REQ-023 FILL SHALL count completed cell writes; after N*N completed writes it SHALL enter DONE.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 wr_addr and wr_data SHALL be 0 whenever wr_en is 0.
REQ-027 Arithmetic SHALL use ADDR_W-wide unsigned products with no truncation of valid addresses.

Reset
REQ-028 rst_n low SHALL force IDLE, all counters 0, wr_en/wr_addr/wr_data/done/err/busy 0, and cell_ready 0, including mid-operation.
REQ-029 A pending unaccepted write SHALL be discarded on reset.

Configuration
REQ-030 With SCORE_RAM_WRITER_BOUNDS_CHECK_EN defined, an accepted cell with cell_i>=N or cell_j>=N SHALL set err, issue no write, and not be counted.
REQ-031 Without the macro, no bounds check SHALL exist, err SHALL be tied 0, and every accepted cell SHALL be written and counted.

Structure
REQ-032 The FSM state enum and the address-compute function SHALL live in the shared package nw_pkg.
REQ-033 The init and cell address/data sequencing SHALL be one sub-module, score_addr_gen; the top module holds the FSM and output register.

Verification (N=4, SCORE_W=9, GAP=-1, macro defined)
REQ-034 start, wr_ready=1: writes addr 0,1,2,3,4 with data 0,-1,-2,-3,-4, then addr 5,10,15,20 with data -1,-2,-3,-4; busy=1.
REQ-035 In FILL, cell i=0 j=0 score 7: write addr 6 data 7; cell i=3 j=3: write addr 24.
REQ-036 wr_ready low for 3 cycles during INIT_ROW at k=2: addr 2 and data -2 held, k=3 follows without gap; in FILL, cell_ready=0 during the stall.
REQ-037 After 16 valid cells: done=1 for exactly one cycle, busy=0, state IDLE; a start pulse mid-FILL has no effect.
REQ-038 Cell i=4 j=0: err=1, no wr_en, fill count unchanged; err stays 1 until reset.
REQ-039 rst_n low during INIT_COL at k=2: all outputs 0 immediately; the next start restarts at addr 0.
